debug_ctrlr: RTL and testbench

//  Downstream of the serial command decoder. Consumes one decoded debug command
//  (fn/addr/data) per out_valid and executes it against the MCU: pause/resume/reset,

---
 rtl/debug_ctrlr_pkg.sv | 52 +++++
 rtl/debug_ctrlr_if.sv | 21 ++
 rtl/debug_ctrlr_bp_table.sv | 82 ++++++++
 rtl/debug_ctrlr.sv | 190 +++++++++++++++++++
 tb/tb_debug_ctrlr.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_ctrlr_pkg.sv
// Shared types for the debug controller: command codes, FSM states,
// the latched command record and the STATUS word layout.
package debug_ctrlr_pkg;

    typedef enum logic [3:0] {
        NONE   = 4'd0,
        PAUSE  = 4'd1,
        RESUME = 4'd2,
        RESET  = 4'd3,
        STATUS = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        REG_RD = 4'd7,
        REG_WR = 4'd8,
        BP_ADD = 4'd9,
        BP_RM  = 4'd10
    } debug_fn_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT_PAUSE,
        S_MEM_WAIT,
        S_RST_HOLD,
        S_DONE
    } ctrl_state_e;

    // Command as captured from the decoder; fn is kept raw so undefined
    // codes survive the latch and can be rejected in EXEC.
    typedef struct packed {
        logic [3:0]  fn;
        logic [31:0] addr;
        logic [31:0] data;
    } dbg_cmd_t;

    // STATUS word field positions
    localparam int ST_PAUSED  = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_CNT_LSB = 4;

    function automatic logic [31:0] status_word(input logic [3:0] cnt,
                                                input logic       full,
                                                input logic       paused);
        logic [31:0] w;
        w                    = '0;
        w[ST_CNT_LSB +: 4]   = cnt;
        w[ST_FULL]           = full;
        w[ST_PAUSED]         = paused;
        return w;
    endfunction

endpackage

// File: rtl/debug_ctrlr_if.sv
// Decoder <-> debug controller command channel. The decoder is the master
// (issues commands), the controller is the slave (returns result/status).
interface debug_ctrlr_if;
    logic [3:0]  debug_fn;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic        out_valid;
    logic        ctrlr_busy;
    logic [31:0] d_rd;
    logic        cmd_err;

    modport master (
        output debug_fn, addr, d_in, out_valid,
        input  ctrlr_busy, d_rd, cmd_err
    );

    modport slave (
        input  debug_fn, addr, d_in, out_valid,
        output ctrlr_busy, d_rd, cmd_err
    );
endinterface

// File: rtl/debug_ctrlr_bp_table.sv
// PC breakpoint table: add into the lowest free slot, remove by value,
// and a combinational match of the live MCU PC against all valid entries.
module bp_table #(
    parameter  int N_BP = 8,
    localparam int CW   = $clog2(N_BP + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          add_en,
    input  logic          rm_en,
    input  logic [31:0]   op_addr,
    input  logic [31:0]   pc,
    output logic          hit,
    output logic          full,
    output logic          add_err,
    output logic          rm_err,
    output logic [CW-1:0] count
);

    logic [N_BP-1:0]        vld_q, vld_nxt;
    logic [N_BP-1:0][31:0]  pc_q;
    logic [N_BP-1:0]        match_pc, match_op, free_oh;
    logic                   dup;

    // per-entry compare against the MCU PC and against the command operand
    always_comb begin
        for (int i = 0; i < N_BP; i++) begin
            match_pc[i] = vld_q[i] && (pc_q[i] == pc);
            match_op[i] = vld_q[i] && (pc_q[i] == op_addr);
        end
    end

    // one-hot of the lowest invalid slot (all zero when full)
    always_comb begin
        logic found;
        free_oh = '0;
        found   = 1'b0;
        for (int i = 0; i < N_BP; i++) begin
            if (!vld_q[i] && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // population count of valid entries
    always_comb begin
        count = '0;
        for (int i = 0; i < N_BP; i++)
            count = count + CW'(vld_q[i]);
    end

    assign dup     = |match_op;
    assign hit     = |match_pc;
    assign full    = &vld_q;
    // a duplicate add succeeds even when the table is full
    assign add_err = full && !dup;
    assign rm_err  = !dup;

    // next valid vector for add/remove
    always_comb begin
        vld_nxt = vld_q;
        if (add_en && !dup)
            vld_nxt = vld_q | free_oh;
        else if (rm_en)
            vld_nxt = vld_q & ~match_op;
    end

    // table storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            pc_q  <= '0;
        end else begin
            vld_q <= vld_nxt;
            for (int i = 0; i < N_BP; i++)
                if (add_en && !dup && free_oh[i])
                    pc_q[i] <= op_addr;
        end
    end

endmodule

// File: rtl/debug_ctrlr.sv
// Debug controller: executes one decoded debug command at a time against
// the MCU (run control, memory, register file, breakpoints) and reports
// result/error back to the decoder.
module debug_ctrlr
    import debug_ctrlr_pkg::*;
#(
    parameter int N_BP        = 8,
    parameter int RST_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    debug_ctrlr_if.slave  dbg,
    output logic          mcu_pause,
    input  logic          mcu_busy,
    output logic          mcu_reset,
    input  logic [31:0]   mcu_pc,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic [4:0]    rf_addr,
    output logic [31:0]   rf_wdata,
    output logic          rf_we,
    input  logic [31:0]   rf_rdata
);

    localparam int CW  = $clog2(N_BP + 1);
    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam int TW  = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e    state_q, state_nxt;
    dbg_cmd_t       cmd_q;
    logic           busy_q, err_q, cmd_err_q;
    logic [31:0]    res_q, d_rd_q;
    logic [RCW-1:0] rst_cnt_q;
    logic [TW-1:0]  tmo_cnt_q;
    logic           paused_q, mask_q;
    logic [31:0]    resume_pc_q;

    logic           accept, exec, tmo_last, bp_add, bp_rm, hit_ok;
    logic           bp_hit, bp_full, bp_add_err, bp_rm_err;
    logic [CW-1:0]  bp_count;

    assign accept   = (state_q == S_IDLE) && dbg.out_valid;
    assign exec     = (state_q == S_EXEC);
    assign tmo_last = (tmo_cnt_q == TW'(MEM_TIMEOUT - 1));

    bp_table #(.N_BP(N_BP)) u_bp (
        .clk     (clk),
        .reset   (reset),
        .add_en  (bp_add),
        .rm_en   (bp_rm),
        .op_addr (cmd_q.addr),
        .pc      (mcu_pc),
        .hit     (bp_hit),
        .full    (bp_full),
        .add_err (bp_add_err),
        .rm_err  (bp_rm_err),
        .count   (bp_count)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:       if (dbg.out_valid) state_nxt = S_EXEC;
            S_EXEC: begin
                case (cmd_q.fn)
                    PAUSE:          state_nxt = paused_q ? S_DONE : S_WAIT_PAUSE;
                    RESET:          state_nxt = S_RST_HOLD;
                    MEM_RD, MEM_WR: state_nxt = paused_q ? S_MEM_WAIT : S_DONE;
                    default:        state_nxt = S_DONE;
                endcase
            end
            S_WAIT_PAUSE: if (!mcu_busy) state_nxt = S_DONE;
            S_MEM_WAIT:   if (mem_ack || tmo_last) state_nxt = S_DONE;
            S_RST_HOLD:   if (rst_cnt_q == '0) state_nxt = S_DONE;
            S_DONE:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // one-cycle strobes issued from EXEC; mem/reg access gated on paused
    always_comb begin
        mem_rd    = exec && (cmd_q.fn == MEM_RD) && paused_q;
        mem_we    = exec && (cmd_q.fn == MEM_WR) && paused_q;
        rf_we     = exec && (cmd_q.fn == REG_WR) && paused_q && (cmd_q.addr[4:0] != 5'd0);
        bp_add    = exec && (cmd_q.fn == BP_ADD);
        bp_rm     = exec && (cmd_q.fn == BP_RM);
        mcu_reset = (state_q == S_RST_HOLD);
    end

    // command latch, execution bookkeeping and result registers; results
    // are registered out of DONE so busy falls one cycle after DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q     <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            cmd_err_q <= 1'b0;
            res_q     <= '0;
            d_rd_q    <= '0;
            rst_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            cmd_err_q <= 1'b0;
            if (accept) begin
                cmd_q  <= '{fn: dbg.debug_fn, addr: dbg.addr, data: dbg.d_in};
                busy_q <= 1'b1;
                err_q  <= 1'b0;
                res_q  <= '0;
            end
            case (state_q)
                S_EXEC: begin
                    rst_cnt_q <= RCW'(RST_CYCLES - 1);
                    tmo_cnt_q <= '0;
                    case (cmd_q.fn)
                        NONE, PAUSE, RESUME, RESET: ;
                        STATUS: res_q <= status_word(4'(bp_count), bp_full, paused_q);
                        MEM_RD, MEM_WR, REG_WR: err_q <= !paused_q;
                        REG_RD: begin
                            err_q <= !paused_q;
                            if (paused_q) res_q <= rf_rdata;
                        end
                        BP_ADD: err_q <= bp_add_err;
                        BP_RM:  err_q <= bp_rm_err;
                        default: err_q <= 1'b1;
                    endcase
                end
                S_MEM_WAIT: begin
                    if (mem_ack) begin
                        if (cmd_q.fn == MEM_RD) res_q <= mem_rdata;
                    end else if (tmo_last) begin
                        err_q <= 1'b1;
                        res_q <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                S_RST_HOLD: rst_cnt_q <= rst_cnt_q - 1'b1;
                S_DONE: begin
                    busy_q    <= 1'b0;
                    cmd_err_q <= err_q;
                    d_rd_q    <= res_q;
                end
                default: ;
            endcase
        end
    end

    // a hit right after RESUME is masked until the PC moves off resume_pc
    assign hit_ok = !paused_q && bp_hit && !(mask_q && (mcu_pc == resume_pc_q));

    // run-control state; PAUSE/RESUME commands override a same-cycle hit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            paused_q    <= 1'b0;
            mask_q      <= 1'b0;
            resume_pc_q <= '0;
        end else begin
            if (mask_q && (mcu_pc != resume_pc_q)) mask_q <= 1'b0;
            if (hit_ok) paused_q <= 1'b1;
            if (exec && (cmd_q.fn == PAUSE)) paused_q <= 1'b1;
            if (exec && (cmd_q.fn == RESUME)) begin
                paused_q    <= 1'b0;
                mask_q      <= 1'b1;
                resume_pc_q <= mcu_pc;
            end
        end
    end

    assign dbg.ctrlr_busy = busy_q;
    assign dbg.d_rd       = d_rd_q;
    assign dbg.cmd_err    = cmd_err_q;
    assign mcu_pause      = paused_q;
    assign mem_addr       = cmd_q.addr;
    assign mem_wdata      = cmd_q.data;
    assign rf_addr        = cmd_q.addr[4:0];
    assign rf_wdata       = cmd_q.data;

endmodule

// File: tb/tb_debug_ctrlr.sv
// Directed bench for debug_ctrlr: small memory responder, combinational
// register-file model and a strobe monitor around the DUT.
module tb_debug_ctrlr;
    import debug_ctrlr_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mcu_pause, mcu_busy, mcu_reset;
    logic [31:0] mcu_pc;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_rd, mem_ack;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata, rf_rdata;
    logic        rf_we;

    int          checks = 0;
    int          passes = 0;
    int          strobe_cnt = 0;
    bit          ack_en = 1'b1;
    logic [31:0] mem_store [0:1023];

    debug_ctrlr_if dbg_if ();

    debug_ctrlr #(.N_BP(8), .RST_CYCLES(4), .MEM_TIMEOUT(255)) dut (
        .clk       (clk),
        .reset     (reset),
        .dbg       (dbg_if),
        .mcu_pause (mcu_pause),
        .mcu_busy  (mcu_busy),
        .mcu_reset (mcu_reset),
        .mcu_pc    (mcu_pc),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .rf_we     (rf_we),
        .rf_rdata  (rf_rdata)
    );

    always #5 clk = ~clk;

    assign rf_rdata = 32'hA5A5_0000 | {27'b0, rf_addr};

    // count every access strobe
    always @(negedge clk)
        if (mem_rd || mem_we || rf_we) strobe_cnt++;

    // memory responder: ack two cycles after the strobe
    initial begin
        logic [9:0] a;
        logic       rd;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (ack_en && (mem_rd || mem_we) && !reset) begin
                a  = mem_addr[11:2];
                rd = mem_rd;
                if (mem_we) mem_store[a] = mem_wdata;
                @(negedge clk);
                @(negedge clk);
                if (rd) mem_rdata = mem_store[a];
                mem_ack = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] d);
        dbg_if.debug_fn  = fn;
        dbg_if.addr      = a;
        dbg_if.d_in      = d;
        dbg_if.out_valid = 1'b1;
        tick(1);
        dbg_if.out_valid = 1'b0;
    endtask

    // returns out_valid->busy-fall latency in cycles
    task automatic wait_idle(output int lat);
        int n;
        n = 0;
        while (dbg_if.ctrlr_busy === 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        check("busy_bound", 32'(n < 400), 32'd1);
        lat = n + 1;
    endtask

    task automatic run(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] d,
                       output int lat);
        issue(fn, a, d);
        wait_idle(lat);
    endtask

    initial begin
        int lat, s0, rc, n;
        reset            = 1'b1;
        dbg_if.debug_fn  = '0;
        dbg_if.addr      = '0;
        dbg_if.d_in      = '0;
        dbg_if.out_valid = 1'b0;
        mcu_busy         = 1'b0;
        mcu_pc           = '0;
        tick(2);
        check("rst_busy",   32'(dbg_if.ctrlr_busy), 32'd0);
        check("rst_d_rd",   dbg_if.d_rd, 32'd0);
        check("rst_err",    32'(dbg_if.cmd_err), 32'd0);
        check("rst_pause",  32'(mcu_pause), 32'd0);
        check("rst_mreset", 32'(mcu_reset), 32'd0);
        check("rst_strobe", 32'({mem_rd, mem_we, rf_we}), 32'd0);
        reset = 1'b0;
        tick(1);

        // PAUSE while the MCU stays busy
        mcu_busy = 1'b1;
        issue(PAUSE, 0, 0);
        check("pause_busy_rise", 32'(dbg_if.ctrlr_busy), 32'd1);
        tick(5);
        check("pause_busy_held", 32'(dbg_if.ctrlr_busy), 32'd1);
        check("pause_mcu_pause", 32'(mcu_pause), 32'd1);
        mcu_busy = 1'b0;
        wait_idle(lat);
        check("pause_err", 32'(dbg_if.cmd_err), 32'd0);
        run(STATUS, 0, 0, lat);
        check("status_paused", dbg_if.d_rd, 32'h0000_0001);
        check("status_lat", 32'(lat), 32'd3);
        run(PAUSE, 0, 0, lat);
        check("repause_lat", 32'(lat), 32'd3);

        // memory and register access while paused
        run(MEM_WR, 32'h100, 32'hDEAD_BEEF, lat);
        check("memwr_err", 32'(dbg_if.cmd_err), 32'd0);
        check("memwr_lat", 32'(lat), 32'd5);
        check("memwr_data", mem_store[64], 32'hDEAD_BEEF);
        run(MEM_RD, 32'h100, 0, lat);
        check("memrd_data", dbg_if.d_rd, 32'hDEAD_BEEF);
        check("memrd_err", 32'(dbg_if.cmd_err), 32'd0);
        check("memrd_lat", 32'(lat), 32'd5);
        s0 = strobe_cnt;
        run(REG_WR, 32'd7, 32'h1234, lat);
        check("regwr_strobe", 32'(strobe_cnt - s0), 32'd1);
        s0 = strobe_cnt;
        run(REG_WR, 32'd0, 32'h1234, lat);
        check("regwr_x0_err", 32'(dbg_if.cmd_err), 32'd0);
        check("regwr_x0_strobe", 32'(strobe_cnt - s0), 32'd0);
        run(REG_RD, 32'd5, 0, lat);
        check("regrd_data", dbg_if.d_rd, 32'hA5A5_0005);

        // access while running is refused without side effects
        run(RESUME, 0, 0, lat);
        check("resume_pause", 32'(mcu_pause), 32'd0);
        s0 = strobe_cnt;
        run(REG_RD, 32'd5, 0, lat);
        check("run_regrd_err", 32'(dbg_if.cmd_err), 32'd1);
        tick(1);
        check("err_pulse_width", 32'(dbg_if.cmd_err), 32'd0);
        run(MEM_WR, 32'h100, 32'h1, lat);
        check("run_memwr_err", 32'(dbg_if.cmd_err), 32'd1);
        check("run_no_strobe", 32'(strobe_cnt - s0), 32'd0);

        // breakpoint hit and resume-at-breakpoint masking
        mcu_pc = 32'h10;
        run(BP_ADD, 32'h40, 0, lat);
        check("bpadd_err", 32'(dbg_if.cmd_err), 32'd0);
        mcu_pc = 32'h3C;
        tick(1);
        mcu_pc = 32'h40;
        check("hit_same_cycle", 32'(mcu_pause), 32'd0);
        tick(1);
        check("hit_pause", 32'(mcu_pause), 32'd1);
        run(STATUS, 0, 0, lat);
        check("status_1bp", dbg_if.d_rd, 32'h0000_0011);
        run(RESUME, 0, 0, lat);
        tick(3);
        check("resume_masked", 32'(mcu_pause), 32'd0);
        mcu_pc = 32'h44;
        tick(1);
        mcu_pc = 32'h40;
        tick(1);
        check("rehit_after_move", 32'(mcu_pause), 32'd1);

        // fill the table, overflow, remove
        for (int i = 0; i < 7; i++) begin
            run(BP_ADD, 32'h200 + 32'(4 * i), 0, lat);
            check("bpfill_err", 32'(dbg_if.cmd_err), 32'd0);
        end
        run(BP_ADD, 32'h40, 0, lat);
        check("bpdup_err", 32'(dbg_if.cmd_err), 32'd0);
        run(BP_ADD, 32'h300, 0, lat);
        check("bpfull_err", 32'(dbg_if.cmd_err), 32'd1);
        run(STATUS, 0, 0, lat);
        check("status_full", dbg_if.d_rd, 32'h0000_0083);
        run(BP_RM, 32'h999, 0, lat);
        check("bprm_miss_err", 32'(dbg_if.cmd_err), 32'd1);
        run(BP_RM, 32'h40, 0, lat);
        check("bprm_err", 32'(dbg_if.cmd_err), 32'd0);
        run(STATUS, 0, 0, lat);
        check("status_7bp", dbg_if.d_rd, 32'h0000_0071);
        run(BP_ADD, 32'h300, 0, lat);
        check("bpreadd_err", 32'(dbg_if.cmd_err), 32'd0);

        // RESET pulse width, state retained
        issue(RESET, 0, 0);
        n  = 0;
        rc = 0;
        while (dbg_if.ctrlr_busy === 1'b1 && n < 50) begin
            tick(1);
            n++;
            if (mcu_reset === 1'b1) rc++;
        end
        check("reset_cycles", 32'(rc), 32'd4);
        check("reset_lat", 32'(n + 1), 32'd7);
        check("reset_keeps_pause", 32'(mcu_pause), 32'd1);
        run(STATUS, 0, 0, lat);
        check("reset_keeps_bp", dbg_if.d_rd, 32'h0000_0083);

        run(4'hF, 0, 0, lat);
        check("undef_fn_err", 32'(dbg_if.cmd_err), 32'd1);

        // memory timeout
        ack_en = 1'b0;
        run(REG_RD, 32'd3, 0, lat);
        check("regrd3_data", dbg_if.d_rd, 32'hA5A5_0003);
        run(MEM_RD, 32'h100, 0, lat);
        check("tmo_err", 32'(dbg_if.cmd_err), 32'd1);
        check("tmo_d_rd", dbg_if.d_rd, 32'd0);
        check("tmo_lat", 32'(lat), 32'd258);

        // async reset in MEM_WAIT
        issue(MEM_RD, 32'h100, 0);
        tick(3);
        check("memwait_busy", 32'(dbg_if.ctrlr_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("areset_busy", 32'(dbg_if.ctrlr_busy), 32'd0);
        check("areset_pause", 32'(mcu_pause), 32'd0);
        check("areset_strobe", 32'({mem_rd, mem_we, rf_we, mcu_reset}), 32'd0);
        check("areset_d_rd", dbg_if.d_rd, 32'd0);
        tick(1);
        reset  = 1'b0;
        ack_en = 1'b1;
        tick(1);
        run(MEM_RD, 32'h100, 0, lat);
        check("post_reset_memrd_err", 32'(dbg_if.cmd_err), 32'd1);
        run(STATUS, 0, 0, lat);
        check("post_reset_status", dbg_if.d_rd, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
